// File: rtl/pc_sequencer.sv
// Program-counter sequencer: resolves relative branches from ALU flags and stalls
// the PC (rel_branch=1, offset=0) for the blocking input instruction and for halt.
module pc_sequencer #(
  parameter int AddrSz         = 6,
  parameter int DebounceCycles = 4
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              br_req,
  input  logic [1:0]        br_cond,
  input  logic [AddrSz-1:0] br_offset,
  input  logic              z_flag,
  input  logic              n_flag,
  input  logic              in_req,
  input  logic              halt_req,
  input  logic              in_btn,
  output logic              rel_branch,
  output logic [AddrSz-1:0] offset,
  output logic              in_capture,
  output logic              commit,
  output logic              halted
);

  localparam int CntW = $clog2(DebounceCycles + 1);
  localparam logic [CntW-1:0] CntMax    = CntW'(DebounceCycles);
  localparam logic [CntW-1:0] CntStable = CntW'(DebounceCycles - 1);

  localparam logic [1:0] ST_RUN          = 2'd0;
  localparam logic [1:0] ST_WAIT_PRESS   = 2'd1;
  localparam logic [1:0] ST_WAIT_RELEASE = 2'd2;
  localparam logic [1:0] ST_HALT         = 2'd3;

  logic [1:0]      r_state;
  logic [1:0]      w_next_state;
  logic            r_sync1;
  logic            r_sync2;
  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_next;
  logic            w_match;
  logic            w_stable;
  logic            w_cond;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= in_btn;
      r_sync2 <= r_sync1;
    end
  end

  // Awaited switch level: high while waiting for the press, low while waiting for release.
  always_comb begin
    w_match = 1'b0;
    case (r_state)
      ST_WAIT_PRESS:   w_match = r_sync2;
      ST_WAIT_RELEASE: w_match = !r_sync2;
      default:         w_match = 1'b0;
    endcase
  end

  assign w_stable = w_match && (r_cnt == CntStable);

  always_comb begin
    case (br_cond)
      2'b00:   w_cond = 1'b1;
      2'b01:   w_cond = z_flag;
      2'b10:   w_cond = !z_flag;
      default: w_cond = n_flag;
    endcase
  end

  // NOTE: every output gets a default first, so no path through the case infers a latch.
  always_comb begin
    rel_branch   = 1'b1;
    offset       = '0;
    in_capture   = 1'b0;
    commit       = 1'b0;
    halted       = 1'b0;
    w_next_state = r_state;
    case (r_state)
      ST_RUN: begin
        if (halt_req) begin
          w_next_state = ST_HALT;
        end else if (in_req) begin
          w_next_state = ST_WAIT_PRESS;
        end else begin
          commit = 1'b1;
          if (br_req && w_cond) offset = br_offset;
          else                  rel_branch = 1'b0;
        end
      end
      ST_WAIT_PRESS: begin
        if (w_stable) begin
          in_capture   = 1'b1;
          w_next_state = ST_WAIT_RELEASE;
        end
      end
      ST_WAIT_RELEASE: begin
        if (w_stable) begin
          rel_branch   = 1'b0;
          commit       = 1'b1;
          w_next_state = ST_RUN;
        end
      end
      ST_HALT: halted = 1'b1;
    endcase
  end

  // Counter restarts on any state change so each wait measures its own stable run.
  always_comb begin
    if (w_next_state != r_state) w_cnt_next = '0;
    else if (!w_match)           w_cnt_next = '0;
    else if (r_cnt == CntMax)    w_cnt_next = r_cnt;
    else                         w_cnt_next = r_cnt + CntW'(1);
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_cnt_next;
    end
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Control block that drives the relative-branch interface of the program counter: `rel_branch` and `offset`.
- Resolves conditional relative branches from ALU flags.
- Stalls the PC for the blocking input instruction, which waits for a debounced press then release of the input switch.
- Stalls the PC permanently on halt.
- Stalls are encoded as `rel_branch=1`, `offset=0`, so the PC holds its address without needing an enable port.

Parameters:
- AddrSz, 6, width of PC address and branch offset.
- DebounceCycles, 4, consecutive stable synchronised samples required to accept a switch level change (must be >=1).

Ports:
- clk  in  1  system clock, all state updates on posedge.
- n_reset  in  1  asynchronous active-low reset.
- br_req  in  1  current instruction is a relative branch.
- br_cond  in  2  branch condition: 00 always, 01 if Z, 10 if !Z, 11 if N.
- br_offset  in  AddrSz  two's-complement branch offset from the instruction.
- z_flag  in  1  ALU zero flag.
- n_flag  in  1  ALU negative flag.
- in_req  in  1  current instruction is the blocking input instruction.
- halt_req  in  1  current instruction is halt.
- in_btn  in  1  raw asynchronous input switch.
- rel_branch  out  1  to PC: add `offset` instead of incrementing.
- offset  out  AddrSz  to PC: offset to add when `rel_branch`=1.
- in_capture  out  1  one-cycle pulse: register file writes the input value.
- commit  out  1  current instruction completes this cycle (PC leaves it on the next edge).
- halted  out  1  sequencer is in HALT.

Behaviour:
- State register, 2 bits: RUN, WAIT_PRESS, WAIT_RELEASE, HALT.
- Reset: async on `n_reset` low.
  - State RUN, synchroniser flops 0, debounce counter 0.
  - Reset mid-wait abandons the instruction; no `in_capture` is emitted.
- Outputs are combinational from state and inputs (the PC samples them at the next posedge).
  - After reset with all requests low: `rel_branch=0`, `offset=0`, `in_capture=0`, `commit=1`, `halted=0`.
- `in_btn` passes through a 2-flop synchroniser; its output is `btn_s`.
- Debounce counter:
  - Width clog2(DebounceCycles+1); it saturates and never wraps.
  - Increments while `btn_s` equals the level awaited by the current state.
  - Clears on mismatch and on every state change.
  - "Stable" means counter == DebounceCycles-1 and `btn_s` matches in the current cycle.
- RUN, priority `halt_req` > `in_req` > `br_req`:
  - `halt_req`: stall; next state HALT; `commit=0`.
  - `in_req`: stall; next state WAIT_PRESS; `commit=0`.
  - `br_req` with condition true: `rel_branch=1`, `offset=br_offset`; `commit=1`.
  - `br_req` with condition false, or no request: `rel_branch=0`, `offset=0`; `commit=1`.
- WAIT_PRESS:
  - Stall; awaited level 1.
  - On stable: `in_capture=1` for this cycle only; next state WAIT_RELEASE.
- WAIT_RELEASE:
  - Awaited level 0; stall until stable.
  - On the stable cycle: `rel_branch=0`, `commit=1`, next state RUN, so the PC increments past the input instruction.
- HALT: stall forever; `halted=1`; only reset exits.
- Offset arithmetic is performed by the PC, modulo 2^AddrSz. The sequencer passes `br_offset` through unmodified; wrap-around is legal.
- Request inputs are ignored outside RUN; the held instruction keeps presenting them.
- A button already pressed on entry to WAIT_PRESS is accepted after DebounceCycles stable samples.
- Glitches shorter than DebounceCycles are rejected.

Test Plan:
- Reset, `br_req=0`, run 5 cycles -> `rel_branch=0` every cycle; PC addr 0,1,2,3,4; `commit=1`.
- `br_req=1`, `br_cond=00`, `br_offset=10`, at addr 3 -> `rel_branch=1`, `offset=10`; next addr 13.
- `br_cond=01`: `z_flag=0` gives increment; `z_flag=1` gives +`br_offset`. `br_cond=11`, `n_flag=1`, `br_offset=6'h3E` (-2) at addr 5 -> next addr 3.
- `in_req=1`, `in_btn` held 0 for 20 cycles:
  - PC addr constant, `commit=0`.
  - Raise `in_btn` -> `in_capture` pulses exactly once, DebounceCycles+2 cycles after the rise (±1 for sync phase).
  - PC still held until `in_btn` falls and is stable.
  - Then one increment; state RUN.
- In WAIT_PRESS, 2-cycle `in_btn` glitch (< DebounceCycles) -> no `in_capture`, PC held.
- `halt_req=1` -> PC addr frozen and `halted=1` for 50 cycles, even with `br_req`/`in_btn` toggling. Also: reset asserted in WAIT_RELEASE -> state RUN, `halted=0`, no capture pulse.
